pll_rst_seq: RTL and testbench
==============================

PLL_RST_SEQ -- requirements
Module: pll_rst_seq

Interface
REQ-001 SHALL have parameter PLL_RST_CYCLES, default 16, giving the number of clk cycles pll_reset is held high per attempt (min 1).
REQ-002 SHALL have parameter LOCK_TIMEOUT, default 270000, giving the maximum clk cycles to wait for lock before retrying (10 ms at 27 MHz).
REQ-003 SHALL have parameter LOCK_STABLE_CYCLES, default 1024, giving the consecutive synced-lock-high cycles required before reset release.
REQ-004 SHALL have port clk, input, 1 bit: 27 MHz oscillator clock; it also feeds PLL clkin.
REQ-005 SHALL have port reset, input, 1 bit: asynchronous, active-high reset, the only reset.
REQ-006 SHALL have port pll_lock, input, 1 bit: PLL lock, asynchronous to clk.
REQ-007 SHALL have port pll_reset, output, 1 bit: drives the PLL reset input, active-high.
REQ-008 SHALL have port rst_out, output, 1 bit: active-high reset for logic clocked by the PLL output.
REQ-009 SHALL have port locked, output, 1 bit: high only in RUN.
REQ-010 SHALL have port retry_cnt, output, 8 bits: saturating count of timeout retries.

Function
REQ-011 pll_lock SHALL pass through a 2-flop synchronizer; the result is lock_s, with 2 cycles latency.
REQ-012 The FSM SHALL have four states: RESET_PLL, WAIT_LOCK, STABLE, RUN. One shared counter cnt, wide enough for the largest parameter, SHALL be cleared on every state entry.
REQ-013 In RESET_PLL, pll_reset SHALL be 1; after PLL_RST_CYCLES cycles in the state, the FSM SHALL go to WAIT_LOCK.
REQ-014 In WAIT_LOCK, lock_s=1 SHALL go to STABLE. Otherwise, when cnt reaches LOCK_TIMEOUT-1, the FSM SHALL go to RESET_PLL and increment retry_cnt. Lock takes priority over timeout in the same cycle.
REQ-015 In STABLE, lock_s=0 SHALL return to WAIT_LOCK with the timeout restarted. After LOCK_STABLE_CYCLES consecutive lock_s=1 cycles, the FSM SHALL go to RUN.
REQ-016 In RUN, lock loss (see REQ-024/025) SHALL go to RESET_PLL; retry_cnt is not incremented.
REQ-017 All outputs SHALL be registered, decoded from the next state: pll_reset=1 iff RESET_PLL; rst_out=0 and locked=1 iff RUN; otherwise rst_out=1 and locked=0.
REQ-018 retry_cnt SHALL saturate at 255 and is cleared only by reset.
REQ-019 pll_lock glitches shorter than one clk period are not guaranteed to be filtered; only the synchronized value is acted on.

Reset
REQ-020 While reset=1, the block SHALL hold: state=RESET_PLL, cnt=0, pll_reset=1, rst_out=1, locked=0, retry_cnt=0, synchronizer flops=0.
REQ-021 Reset assertion mid-operation (any state) SHALL force the REQ-020 values asynchronously.
REQ-022 After reset deassertion, a full PLL_RST_CYCLES pulse SHALL be issued before the first WAIT_LOCK.

Configuration
REQ-023 The macro LOCK_LOSS_FILTER_EN SHALL select lock-loss filtering in RUN.
REQ-024 With LOCK_LOSS_FILTER_EN defined, RUN SHALL leave only after 4 consecutive lock_s=0 cycles; a shorter low run resets the filter count, and locked/rst_out stay unchanged during filtering.
REQ-025 Without LOCK_LOSS_FILTER_EN, a single lock_s=0 cycle in RUN SHALL leave RUN; no filter register exists.

Structure
REQ-026 Shared package pll_rst_pkg SHALL hold the FSM state typedef (2-bit enum), the default parameter constants and the filter depth constant (4).
REQ-027 The synchronizer SHALL be a sub-module sync_2ff (1-bit, asynchronous active-high reset to 0) so it can be reused for other CDC bits.

Verification
Test parameters: PLL_RST_CYCLES=4, LOCK_TIMEOUT=100, LOCK_STABLE_CYCLES=8.
REQ-028 Release reset with pll_lock=1 constant -> pll_reset high exactly 4 cycles; rst_out falls and locked rises 8 stable cycles plus sync/register latency after lock_s; retry_cnt=0.
REQ-029 Hold pll_lock=0 for 350 cycles after reset -> 3 timeouts, 3 pll_reset pulses of 4 cycles each, retry_cnt=3, rst_out stays 1.
REQ-030 Toggle pll_lock low for 1 cycle during STABLE at count 5 -> return to WAIT_LOCK, stable count restarts, RUN is reached 8 full stable cycles later.
REQ-031 In RUN, drop pll_lock for 2 cycles -> with LOCK_LOSS_FILTER_EN: stays in RUN, locked=1; without: pll_reset pulses and rst_out=1. Drop for 6 cycles -> both builds enter RESET_PLL.
REQ-032 Force 300 timeouts -> retry_cnt saturates at 255; assert reset mid-WAIT_LOCK -> all outputs take their REQ-020 values within the same cycle.
REQ-033 Lock rising in the same cycle cnt=99 in WAIT_LOCK -> FSM goes to STABLE, no retry, retry_cnt unchanged.

Source files
------------

// File: rtl/pll_rst_pkg.sv
// Shared definitions for the PLL reset sequencer.
//   - pll_state_t   : sequencer FSM state (2-bit enum)
//   - DEF_*         : default values for the sequencer parameters
//   - LOCK_FLT_DEPTH: consecutive low lock samples needed to leave RUN when
//                     lock-loss filtering is built in (LOCK_LOSS_FILTER_EN)
//   - max3          : helper used to size the shared cycle counter
package pll_rst_pkg;

  typedef enum logic [1:0] {
    RESET_PLL = 2'd0,
    WAIT_LOCK = 2'd1,
    STABLE    = 2'd2,
    RUN       = 2'd3
  } pll_state_t;

  localparam int DEF_PLL_RST_CYCLES     = 16;
  localparam int DEF_LOCK_TIMEOUT       = 270000;  // 10 ms at 27 MHz
  localparam int DEF_LOCK_STABLE_CYCLES = 1024;
  localparam int LOCK_FLT_DEPTH         = 4;

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for a single asynchronous bit.
// Ports:
//   clk - destination clock
//   rst - asynchronous active-high reset, clears both flops to 0
//   d   - asynchronous input bit
//   q   - synchronized output, 2 clk cycles of latency
module sync_2ff (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      meta <= 1'b0;
      q    <= 1'b0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/pll_rst_seq.sv
// PLL reset sequencer. Pulses the PLL reset, waits for lock (retrying on
// timeout), requires lock to stay high for a stable window, then releases the
// reset of the PLL-clocked domain. Lock loss while running restarts the
// sequence.
// Parameters:
//   PLL_RST_CYCLES     - cycles pll_reset is held per attempt (>= 1)
//   LOCK_TIMEOUT       - cycles to wait for lock before retrying
//   LOCK_STABLE_CYCLES - consecutive lock cycles required before release
// Ports:
//   clk       - 27 MHz oscillator clock (also the PLL reference)
//   reset     - asynchronous active-high reset
//   pll_lock  - PLL lock indicator, asynchronous to clk
//   pll_reset - PLL reset, active-high (registered)
//   rst_out   - reset for PLL-clocked logic, active-high (registered)
//   locked    - high only in RUN (registered)
//   retry_cnt - saturating count of lock timeouts
//   dbg_state - current FSM state, for observation only
// Build option: define LOCK_LOSS_FILTER_EN to leave RUN only after
// LOCK_FLT_DEPTH consecutive low lock samples instead of a single one.
module pll_rst_seq
  import pll_rst_pkg::*;
#(
  parameter int PLL_RST_CYCLES     = DEF_PLL_RST_CYCLES,
  parameter int LOCK_TIMEOUT       = DEF_LOCK_TIMEOUT,
  parameter int LOCK_STABLE_CYCLES = DEF_LOCK_STABLE_CYCLES
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       pll_lock,
  output logic       pll_reset,
  output logic       rst_out,
  output logic       locked,
  output logic [7:0] retry_cnt,
  output logic [1:0] dbg_state
);

  localparam int CNT_MAX = max3(PLL_RST_CYCLES, LOCK_TIMEOUT, LOCK_STABLE_CYCLES);
  localparam int CNT_W   = $clog2(CNT_MAX + 1);

  localparam logic [CNT_W-1:0] RST_LAST = CNT_W'(PLL_RST_CYCLES - 1);
  localparam logic [CNT_W-1:0] TO_LAST  = CNT_W'(LOCK_TIMEOUT - 1);
  localparam logic [CNT_W-1:0] STB_LAST = CNT_W'(LOCK_STABLE_CYCLES - 1);

  pll_state_t       state;
  pll_state_t       state_next;
  logic [CNT_W-1:0] cnt;
  logic             lock_s;
  logic             timeout;
  logic             leave_run;

  sync_2ff u_lock_sync (
    .clk (clk),
    .rst (reset),
    .d   (pll_lock),
    .q   (lock_s)
  );

`ifdef LOCK_LOSS_FILTER_EN
  localparam int               FLT_W    = $clog2(LOCK_FLT_DEPTH);
  localparam logic [FLT_W-1:0] FLT_LAST = FLT_W'(LOCK_FLT_DEPTH - 1);

  // Number of consecutive low lock samples seen so far in RUN.
  logic [FLT_W-1:0] flt_cnt;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      flt_cnt <= '0;
    end else if (state != RUN || lock_s || leave_run) begin
      flt_cnt <= '0;
    end else begin
      flt_cnt <= flt_cnt + FLT_W'(1);
    end
  end

  assign leave_run = !lock_s && (flt_cnt == FLT_LAST);
`else
  assign leave_run = !lock_s;
`endif

  always_comb begin
    state_next = state;
    timeout    = 1'b0;
    case (state)
      RESET_PLL: begin
        if (cnt == RST_LAST) state_next = WAIT_LOCK;
      end
      WAIT_LOCK: begin
        // Lock wins over a timeout landing in the same cycle.
        if (lock_s) begin
          state_next = STABLE;
        end else if (cnt == TO_LAST) begin
          state_next = RESET_PLL;
          timeout    = 1'b1;
        end
      end
      STABLE: begin
        if (!lock_s)              state_next = WAIT_LOCK;
        else if (cnt == STB_LAST) state_next = RUN;
      end
      RUN: begin
        if (leave_run) state_next = RESET_PLL;
      end
      default: state_next = RESET_PLL;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= RESET_PLL;
      cnt       <= '0;
      pll_reset <= 1'b1;
      rst_out   <= 1'b1;
      locked    <= 1'b0;
      retry_cnt <= '0;
    end else begin
      state <= state_next;
      // Counter restarts on every state entry; RUN does not use it.
      if (state_next != state || state == RUN) cnt <= '0;
      else                                     cnt <= cnt + CNT_W'(1);
      if (timeout && retry_cnt != 8'hFF) retry_cnt <= retry_cnt + 8'd1;
      // Outputs decoded from the next state so they line up with it.
      pll_reset <= (state_next == RESET_PLL);
      rst_out   <= (state_next != RUN);
      locked    <= (state_next == RUN);
    end
  end

  assign dbg_state = state;

endmodule

// File: tb/tb_pll_rst_seq.sv
// Self-checking bench for pll_rst_seq with PLL_RST_CYCLES=4, LOCK_TIMEOUT=100,
// LOCK_STABLE_CYCLES=8. A cycle-level reference model tracks the sequencing
// phase and the time spent in it; every scenario compares the DUT outputs
// against it each cycle, plus scenario-specific timing checks.
module tb_pll_rst_seq;

  localparam int PRC = 4;
  localparam int TO  = 100;
  localparam int SC  = 8;
`ifdef LOCK_LOSS_FILTER_EN
  localparam int LOSS_N = 4;
`else
  localparam int LOSS_N = 1;
`endif

  localparam int P_RST  = 0;
  localparam int P_WAIT = 1;
  localparam int P_STB  = 2;
  localparam int P_RUN  = 3;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       pll_lock = 1'b0;
  logic       pll_reset;
  logic       rst_out;
  logic       locked;
  logic [7:0] retry_cnt;
  logic [1:0] dbg_state;
  logic [10:0] act;

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  // Reference model
  int   m_phase;
  int   m_t;
  int   m_low;
  int   m_retry;
  logic h1, h2;

  pll_rst_seq #(
    .PLL_RST_CYCLES     (PRC),
    .LOCK_TIMEOUT       (TO),
    .LOCK_STABLE_CYCLES (SC)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .pll_lock  (pll_lock),
    .pll_reset (pll_reset),
    .rst_out   (rst_out),
    .locked    (locked),
    .retry_cnt (retry_cnt),
    .dbg_state (dbg_state)
  );

  always #5 clk = ~clk;

  assign act = {pll_reset, rst_out, locked, retry_cnt};

  function automatic logic [10:0] exp_vec();
    return {m_phase == P_RST, m_phase != P_RUN, m_phase == P_RUN, 8'(m_retry)};
  endfunction

  task automatic model_reset();
    m_phase = P_RST;
    m_t     = 0;
    m_low   = 0;
    m_retry = 0;
    h1      = 1'b0;
    h2      = 1'b0;
  endtask

  // Advance the model by one clk edge; lk is pll_lock as seen at that edge.
  task automatic model_step(input logic lk);
    logic ls;
    ls = h2;
    h2 = h1;
    h1 = lk;
    if (m_phase == P_RST) begin
      if (m_t == PRC - 1) begin m_phase = P_WAIT; m_t = 0; end
      else m_t++;
    end else if (m_phase == P_WAIT) begin
      if (ls) begin
        m_phase = P_STB; m_t = 0;
      end else if (m_t == TO - 1) begin
        m_phase = P_RST; m_t = 0;
        if (m_retry < 255) m_retry++;
      end else m_t++;
    end else if (m_phase == P_STB) begin
      if (!ls) begin m_phase = P_WAIT; m_t = 0; end
      else if (m_t == SC - 1) begin m_phase = P_RUN; m_t = 0; m_low = 0; end
      else m_t++;
    end else begin
      m_low = ls ? 0 : m_low + 1;
      if (m_low >= LOSS_N) begin m_phase = P_RST; m_t = 0; m_low = 0; end
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    model_step(pll_lock);
    cyc++;
  endtask

  task automatic do_reset(input logic lk);
    reset = 1'b1;
    pll_lock = lk;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    model_reset();
    cyc = 0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    pll_lock = 1'($urandom_range(0, 1));
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (act !== 11'b110_00000000) begin
      failures++;
      $display("FAIL reset_outputs act=%b exp=%b", act, 11'b110_00000000);
    end
    checks++;
    if (dbg_state !== 2'd0) begin
      failures++;
      $display("FAIL reset_state act=%0d exp=0", dbg_state);
    end
  endtask

  // Lock high from reset release: 4-cycle pulse, release 13 cycles later.
  task automatic test_lock_const();
    int hi;
    int first_lock;
    do_reset(1'b1);
    hi = pll_reset ? 1 : 0;
    first_lock = -1;
    for (int i = 1; i <= 30; i++) begin
      step();
      checks++;
      if (act !== exp_vec()) begin
        failures++;
        $display("FAIL lockstep_const cyc=%0d act=%b exp=%b", cyc, act, exp_vec());
      end
      if (pll_reset) hi++;
      if (locked && first_lock < 0) first_lock = i;
    end
    checks++;
    if (hi != PRC) begin
      failures++;
      $display("FAIL const_pulse_len act=%0d exp=%0d", hi, PRC);
    end
    checks++;
    if (first_lock != PRC + 1 + SC) begin
      failures++;
      $display("FAIL const_lock_time act=%0d exp=%0d", first_lock, PRC + 1 + SC);
    end
    checks++;
    if (retry_cnt !== 8'd0 || rst_out !== 1'b0) begin
      failures++;
      $display("FAIL const_final act=retry %0d rst_out %b exp=retry 0 rst_out 0", retry_cnt, rst_out);
    end
  endtask

  // Lock never arrives: 3 timeouts in 350 cycles.
  task automatic test_timeout();
    int rises;
    int hi;
    int rst_low;
    logic prev;
    do_reset(1'b0);
    rises = 0; hi = 1; rst_low = 0; prev = pll_reset;
    for (int i = 1; i <= 350; i++) begin
      step();
      checks++;
      if (act !== exp_vec()) begin
        failures++;
        $display("FAIL lockstep_timeout cyc=%0d act=%b exp=%b", cyc, act, exp_vec());
      end
      if (pll_reset && !prev) rises++;
      if (pll_reset) hi++;
      if (!rst_out) rst_low++;
      prev = pll_reset;
    end
    checks++;
    if (rises != 3 || hi != 4 * PRC) begin
      failures++;
      $display("FAIL timeout_pulses act=rises %0d high %0d exp=rises 3 high %0d", rises, hi, 4 * PRC);
    end
    checks++;
    if (retry_cnt !== 8'd3 || rst_low != 0) begin
      failures++;
      $display("FAIL timeout_retry act=retry %0d rst_low %0d exp=retry 3 rst_low 0", retry_cnt, rst_low);
    end
  endtask

  // One-cycle lock drop seen while the stable count is 5.
  task automatic test_stable_glitch();
    int first_lock;
    first_lock = -1;
    do_reset(1'b1);
    for (int i = 1; i <= 30; i++) begin
      step();
      checks++;
      if (act !== exp_vec()) begin
        failures++;
        $display("FAIL lockstep_glitch cyc=%0d act=%b exp=%b", cyc, act, exp_vec());
      end
      if (locked && first_lock < 0) first_lock = i;
      if (i == 8) pll_lock = 1'b0;
      if (i == 9) pll_lock = 1'b1;
    end
    checks++;
    if (first_lock != 20) begin
      failures++;
      $display("FAIL glitch_lock_time act=%0d exp=20", first_lock);
    end
  endtask

  // Lock loss while running, short and long drops, then random drops.
  task automatic test_run_loss();
    int saw_prst;
    int saw_unlock;
    do_reset(1'b1);
    for (int i = 1; i <= 20; i++) step();
    for (int k = 0; k < 2; k++) begin
      saw_prst = 0; saw_unlock = 0;
      for (int i = 1; i <= 12; i++) begin
        if (i == 1) pll_lock = 1'b0;
        if (i == (k == 0 ? 3 : 7)) pll_lock = 1'b1;
        step();
        checks++;
        if (act !== exp_vec()) begin
          failures++;
          $display("FAIL lockstep_loss cyc=%0d act=%b exp=%b", cyc, act, exp_vec());
        end
        if (pll_reset) saw_prst++;
        if (!locked || rst_out) saw_unlock++;
      end
      checks++;
      if (k == 0) begin
`ifdef LOCK_LOSS_FILTER_EN
        if (saw_prst != 0 || saw_unlock != 0) begin
          failures++;
          $display("FAIL loss2_filtered act=prst %0d unlock %0d exp=0 0", saw_prst, saw_unlock);
        end
`else
        if (saw_prst == 0 || saw_unlock == 0) begin
          failures++;
          $display("FAIL loss2_unfiltered act=prst %0d unlock %0d exp=nonzero", saw_prst, saw_unlock);
        end
`endif
      end else begin
        if (saw_prst != PRC) begin
          failures++;
          $display("FAIL loss6_prst act=%0d exp=%0d", saw_prst, PRC);
        end
      end
      for (int i = 1; i <= 30; i++) step();
      checks++;
      if (locked !== 1'b1) begin
        failures++;
        $display("FAIL loss_recover act=%b exp=1", locked);
      end
    end
    for (int k = 0; k < 8; k++) begin
      int len;
      len = $urandom_range(1, 6);
      for (int i = 0; i < len + 30; i++) begin
        pll_lock = (i < len) ? 1'b0 : 1'b1;
        step();
        checks++;
        if (act !== exp_vec()) begin
          failures++;
          $display("FAIL lockstep_rand_loss len=%0d cyc=%0d act=%b exp=%b", len, cyc, act, exp_vec());
        end
      end
    end
  endtask

  // 300 timeouts saturate the retry count; async reset mid-WAIT_LOCK.
  task automatic test_saturate();
    do_reset(1'b0);
    for (int i = 1; i <= 300 * (PRC + TO) + 100; i++) begin
      step();
      checks++;
      if (act !== exp_vec()) begin
        failures++;
        $display("FAIL lockstep_sat cyc=%0d act=%b exp=%b", cyc, act, exp_vec());
      end
    end
    checks++;
    if (retry_cnt !== 8'd255 || dbg_state !== 2'd1) begin
      failures++;
      $display("FAIL sat_value act=retry %0d state %0d exp=retry 255 state 1", retry_cnt, dbg_state);
    end
    #2;
    reset = 1'b1;
    #1;
    checks++;
    if (act !== 11'b110_00000000 || dbg_state !== 2'd0) begin
      failures++;
      $display("FAIL async_reset act=%b state %0d exp=%b state 0", act, dbg_state, 11'b110_00000000);
    end
    @(posedge clk);
    #1;
    checks++;
    if (act !== 11'b110_00000000) begin
      failures++;
      $display("FAIL reset_hold act=%b exp=%b", act, 11'b110_00000000);
    end
    reset = 1'b0;
    model_reset();
  endtask

  // Lock arriving exactly at the last timeout cycle, and one cycle too late.
  task automatic test_lock_at_timeout();
    for (int k = 0; k < 2; k++) begin
      do_reset(1'b0);
      for (int i = 1; i <= 110; i++) begin
        step();
        checks++;
        if (act !== exp_vec()) begin
          failures++;
          $display("FAIL lockstep_edge cyc=%0d act=%b exp=%b", cyc, act, exp_vec());
        end
        if (i == 101 + k) pll_lock = 1'b1;
        if (i == 104) begin
          checks++;
          if (k == 0 && (pll_reset !== 1'b0 || retry_cnt !== 8'd0 || dbg_state !== 2'd2)) begin
            failures++;
            $display("FAIL lock_wins act=prst %b retry %0d state %0d exp=0 0 2", pll_reset, retry_cnt, dbg_state);
          end
          if (k == 1 && (pll_reset !== 1'b1 || retry_cnt !== 8'd1)) begin
            failures++;
            $display("FAIL lock_late act=prst %b retry %0d exp=1 1", pll_reset, retry_cnt);
          end
        end
      end
    end
  endtask

  // Random lock waveform, long and short runs of each level.
  task automatic test_random();
    do_reset(1'($urandom_range(0, 1)));
    for (int s = 0; s < 40; s++) begin
      int len;
      pll_lock = 1'($urandom_range(0, 1));
      len = ($urandom_range(0, 3) == 0) ? $urandom_range(20, 150) : $urandom_range(1, 12);
      for (int i = 0; i < len; i++) begin
        step();
        checks++;
        if (act !== exp_vec()) begin
          failures++;
          $display("FAIL lockstep_random cyc=%0d act=%b exp=%b", cyc, act, exp_vec());
        end
      end
    end
  endtask

  initial begin
    model_reset();
    test_reset();
    test_lock_const();
    test_timeout();
    test_stable_glitch();
    test_run_loss();
    test_saturate();
    test_lock_at_timeout();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog act=running exp=finished");
    $fatal(1, "watchdog expired");
  end

endmodule
